// File: rtl/neuron_mac.sv
// neuron_mac
// Sequential multiply-accumulate neuron core. Accepts a stream of
// (x, w) pairs in 16-bit sign-magnitude Q7.8, accumulates the truncated
// products in a 32-bit two's-complement accumulator, adds a bias,
// saturates to sign-magnitude Q7.8 and holds the result on sum.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   en          start pulse, sampled only in IDLE
//   n           number of terms, sampled with en
//   bias        sign-magnitude Q7.8 bias, sampled with en
//   data_valid  x/w carry a valid term this cycle
//   x, w        sign-magnitude Q7.8 input and weight
//   in_ready    a term is accepted this cycle (high in ACC)
//   busy        operation in progress (ACC or FIN)
//   sum         sign-magnitude Q7.8 result, held until the next result
//   ready       sum is valid; high from completion until the next accepted en
module neuron_mac #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] n,
  input  logic [15:0]      bias,
  input  logic             data_valid,
  input  logic [15:0]      x,
  input  logic [15:0]      w,
  output logic             in_ready,
  output logic             busy,
  output logic [15:0]      sum,
  output logic             ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   cnt;
  logic [15:0]        bias_q;
  logic signed [31:0] acc;

  logic               take;
  logic [29:0]        mag;
  logic [31:0]        term;
  logic signed [31:0] term_s;
  logic signed [31:0] bias_tc;
  logic signed [31:0] r;
  logic [31:0]        r_abs;
  logic [14:0]        r_mag;
  logic [15:0]        sum_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; n = 0 skips straight to FIN
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = (n != '0) ? ACC : FIN;
      ACC:  if (take && cnt == CNT_W'(1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready = (state == ACC);
    busy     = (state != IDLE);
  end

  assign take = data_valid && in_ready;

  // Term: magnitude product truncated by 8 fractional bits. A zero term
  // negates to zero, so negative zero contributes nothing.
  always_comb begin
    mag    = {15'b0, x[14:0]} * {15'b0, w[14:0]};
    term   = {2'b00, mag} >> 8;
    term_s = (x[15] ^ w[15]) ? -signed'(term) : signed'(term);
  end

  // Bias conversion, final add and saturation to 15-bit magnitude.
  // A negative r always has a nonzero magnitude, so 0x8000 cannot occur.
  always_comb begin
    bias_tc  = bias_q[15] ? -signed'({17'b0, bias_q[14:0]})
                          :  signed'({17'b0, bias_q[14:0]});
    r        = acc + bias_tc;
    r_abs    = r[31] ? unsigned'(-r) : unsigned'(r);
    r_mag    = (r_abs > 32'h0000_7FFF) ? 15'h7FFF : r_abs[14:0];
    sum_next = {r[31], r_mag};
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      bias_q <= '0;
      acc    <= '0;
      sum    <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            cnt    <= n;
            bias_q <= bias;
            acc    <= '0;
            ready  <= 1'b0;
          end
        end
        ACC: begin
          if (take) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc + term_s;
          end
        end
        FIN: begin
          sum   <= sum_next;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac
// Self-checking bench for neuron_mac: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_neuron_mac;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] n;
  logic [15:0]      bias;
  logic             data_valid;
  logic [15:0]      x;
  logic [15:0]      w;
  logic             in_ready;
  logic             busy;
  logic [15:0]      sum;
  logic             ready;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] xs [0:255];
  logic [15:0] ws [0:255];
  logic [15:0] prev_sum;
  logic [15:0] exp_sum;
  int          ready_cycle;
  int          ir_cycles;

  neuron_mac #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .n          (n),
    .bias       (bias),
    .data_valid (data_valid),
    .x          (x),
    .w          (w),
    .in_ready   (in_ready),
    .busy       (busy),
    .sum        (sum),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer sum of truncated magnitude products plus bias,
  // then clamp magnitude to 0x7FFF and encode as sign-magnitude.
  function automatic logic [15:0] refSum(input int nt, input logic [15:0] b);
    longint total;
    longint m;
    longint amag;
    total = 0;
    for (int i = 0; i < nt; i++) begin
      m = (longint'(xs[i][14:0]) * longint'(ws[i][14:0])) / 256;
      if (xs[i][15] ^ ws[i][15]) total -= m;
      else total += m;
    end
    if (b[15]) total -= longint'(b[14:0]);
    else total += longint'(b[14:0]);
    amag = (total < 0) ? -total : total;
    if (amag > 32767) amag = 32767;
    return {(total < 0), amag[14:0]};
  endfunction

  // Runs one operation starting just after a clock edge with the block idle.
  // Cycle 1 is the first cycle after the edge that accepts en.
  task automatic applyStimulus(input int nt, input logic [15:0] b,
                               input int stall_a, input int stall_b,
                               input bit poke_en);
    int taken;
    int c;
    bit exp_acc;
    int nstall;
    taken = 0;
    ready_cycle = -1;
    ir_cycles = 0;
    nstall = (stall_a > 0 ? 1 : 0) + (stall_b > 0 ? 1 : 0);
    exp_sum = refSum(nt, b);
    en = 1'b1;
    n = CNT_W'(nt);
    bias = b;
    data_valid = 1'b0;
    @(posedge clk); #1;
    c = 1;
    while (c <= 400) begin
      if (c == 1) begin
        checkOutput("sum_hold", {16'b0, sum}, {16'b0, prev_sum});
        checkOutput("ready_drop", {31'b0, ready}, 32'd0);
      end
      if (ready) begin
        ready_cycle = c;
        break;
      end
      exp_acc = (taken < nt);
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_acc});
      checkOutput("busy", {31'b0, busy}, 32'd1);
      if (in_ready) ir_cycles++;
      en = (poke_en && c == 2);
      n = CNT_W'(5);
      bias = 16'($urandom);
      if (exp_acc && c != stall_a && c != stall_b) begin
        data_valid = 1'b1;
        x = xs[taken];
        w = ws[taken];
        taken++;
      end else begin
        data_valid = exp_acc ? 1'b0 : 1'($urandom_range(0, 1));
        x = 16'($urandom);
        w = 16'($urandom);
      end
      @(posedge clk); #1;
      c++;
    end
    en = 1'b0;
    data_valid = 1'b0;
    checkOutput("sum", {16'b0, sum}, {16'b0, exp_sum});
    checkOutput("ready_cycle", ready_cycle, nt + 2 + nstall);
    checkOutput("in_ready_cycles", ir_cycles, nt + nstall);
    checkOutput("busy_done", {31'b0, busy}, 32'd0);
    prev_sum = exp_sum;
  endtask

  initial begin
    int nt;
    int sa;
    int sb;
    logic [15:0] b;

    rst = 1'b1;
    en = 1'b0;
    n = '0;
    bias = '0;
    data_valid = 1'b0;
    x = '0;
    w = '0;
    prev_sum = 16'h0000;

    // Reset with random inputs
    repeat (2) begin
      en = 1'($urandom);
      n = CNT_W'($urandom);
      bias = 16'($urandom);
      data_valid = 1'($urandom);
      x = 16'($urandom);
      w = 16'($urandom);
      @(posedge clk);
    end
    #1;
    checkOutput("rst_sum", {16'b0, sum}, 32'h0);
    checkOutput("rst_ready", {31'b0, ready}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    en = 1'b0;
    data_valid = 1'b0;
    @(posedge clk); #1;

    xs[0] = 16'h0100; ws[0] = 16'h0100;
    applyStimulus(1, 16'h0000, -1, -1, 1'b0);

    // Basic sum
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    xs[1] = 16'h0200; ws[1] = 16'h0080;
    xs[2] = 16'h8080; ws[2] = 16'h0200;
    applyStimulus(3, 16'h0040, -1, -1, 1'b0);
    checkOutput("basic_sum_const", {16'b0, sum}, 32'h0140);
    checkOutput("basic_ready_cycle", ready_cycle, 5);

    // Saturation and sign
    xs[0] = 16'h7F00; ws[0] = 16'h7F00;
    xs[1] = 16'h7F00; ws[1] = 16'h7F00;
    applyStimulus(2, 16'h0000, -1, -1, 1'b0);
    checkOutput("sat_pos", {16'b0, sum}, 32'h7FFF);
    ws[0] = 16'hFF00; ws[1] = 16'hFF00;
    applyStimulus(2, 16'h0000, -1, -1, 1'b0);
    checkOutput("sat_neg", {16'b0, sum}, 32'hFFFF);

    // Zero and negative zero
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    applyStimulus(1, 16'h8100, -1, -1, 1'b0);
    checkOutput("zero_cancel", {16'b0, sum}, 32'h0000);
    xs[0] = 16'h0001; ws[0] = 16'h8001;
    applyStimulus(1, 16'h0000, -1, -1, 1'b0);
    checkOutput("neg_zero", {16'b0, sum}, 32'h0000);
    applyStimulus(0, 16'h8100, -1, -1, 1'b0);
    checkOutput("n0_sum", {16'b0, sum}, 32'h8100);
    checkOutput("n0_ready_cycle", ready_cycle, 2);

    // Stalls plus ignored en mid-ACC
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    xs[1] = 16'h0200; ws[1] = 16'h0080;
    xs[2] = 16'h8080; ws[2] = 16'h0200;
    sa = $urandom_range(1, 3);
    sb = $urandom_range(sa + 1, 4);
    applyStimulus(3, 16'h0040, sa, sb, 1'b1);
    checkOutput("stall_sum", {16'b0, sum}, 32'h0140);
    checkOutput("stall_ready_cycle", ready_cycle, 7);

    // Reset after one of three terms
    xs[0] = 16'h7F00; ws[0] = 16'h7F00;
    en = 1'b1; n = CNT_W'(3); bias = 16'h0040;
    @(posedge clk); #1;
    en = 1'b0; data_valid = 1'b1; x = xs[0]; w = ws[0];
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    data_valid = 1'b0;
    checkOutput("abort_sum", {16'b0, sum}, 32'h0);
    checkOutput("abort_ready", {31'b0, ready}, 32'd0);
    checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    prev_sum = 16'h0000;
    xs[0] = 16'h0100; ws[0] = 16'h8100;
    applyStimulus(1, 16'h0000, -1, -1, 1'b0);
    checkOutput("post_abort_sum", {16'b0, sum}, 32'h8100);

    // Randomized operations
    for (int k = 0; k < 25; k++) begin
      nt = $urandom_range(0, 8);
      for (int i = 0; i < nt; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          xs[i] = 16'($urandom);
          ws[i] = 16'($urandom);
        end else begin
          xs[i] = {1'($urandom), 5'b0, 10'($urandom)};
          ws[i] = {1'($urandom), 5'b0, 10'($urandom)};
        end
      end
      b = 16'($urandom);
      if (nt >= 2 && $urandom_range(0, 1) == 1) begin
        sa = $urandom_range(1, nt);
        sb = $urandom_range(sa + 1, nt + 1);
      end else begin
        sa = -1;
        sb = -1;
      end
      applyStimulus(nt, b, sa, sb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
